// File: rtl/sbox_timing_harness_if.sv
// Valid/ready stream bundle carrying NBYTES byte lanes plus a per-word bypass flag.
// The master drives valid/data/bypass; the slave drives ready.
interface sbox_timing_harness_if #(
  parameter int unsigned NBYTES = 2
) ();
  logic                  valid;
  logic                  ready;
  logic                  bypass;
  logic [8*NBYTES-1:0]   data;

  modport master (output valid, output data, output bypass, input ready);
  modport slave  (input valid, input data, input bypass, output ready);
endinterface

// File: rtl/sbox_timing_harness.sv
// Handshaked multi-lane inverse S-box stage: IN_STAGES regs -> per-lane invSubBytes -> OUT_STAGES regs.
// Optional output signature register enabled by `define SBOX_TT_SIGNATURE_EN.
module sbox_timing_harness #(
  parameter int unsigned NBYTES     = 2,
  parameter int unsigned IN_STAGES  = 1,
  parameter int unsigned OUT_STAGES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  sbox_timing_harness_if.slave       in_if,
  sbox_timing_harness_if.master      out_if,
  output logic [15:0]                xfer_count,
  output logic [8*NBYTES-1:0]        sig_out
);
  localparam int unsigned W = 8 * NBYTES;

  // Row-major inverse S-box; InvSbox[0] is the leftmost byte.
  localparam logic [0:255][7:0] InvSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [IN_STAGES-1:0]  in_vld_q;
  logic [IN_STAGES-1:0]  in_byp_q;
  logic [W-1:0]          in_dat_q  [IN_STAGES];
  logic [OUT_STAGES-1:0] out_vld_q;
  logic [W-1:0]          out_dat_q [OUT_STAGES];
  logic [W-1:0]          lane_dat;
  logic                  stall;
  logic                  out_xfer;

  // Global stall freezes every stage; in_ready is a combinational function of out_ready.
  assign stall         = out_vld_q[OUT_STAGES-1] && !out_if.ready;
  assign in_if.ready   = !stall;
  assign out_if.valid  = out_vld_q[OUT_STAGES-1];
  assign out_if.data   = out_dat_q[OUT_STAGES-1];
  assign out_if.bypass = 1'b0;
  assign out_xfer      = out_if.valid && out_if.ready;

  always_comb begin
    lane_dat = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      lane_dat[8*k +: 8] = in_byp_q[IN_STAGES-1] ? in_dat_q[IN_STAGES-1][8*k +: 8]
                                                  : InvSbox[in_dat_q[IN_STAGES-1][8*k +: 8]];
    end
  end

  // Stage data only loads behind a valid word so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld_q  <= '0;
      in_byp_q  <= '0;
      out_vld_q <= '0;
      for (int i = 0; i < int'(IN_STAGES); i++)  in_dat_q[i]  <= '0;
      for (int i = 0; i < int'(OUT_STAGES); i++) out_dat_q[i] <= '0;
    end else if (!stall) begin
      in_vld_q[0] <= in_if.valid;
      if (in_if.valid) begin
        in_dat_q[0] <= in_if.data;
        in_byp_q[0] <= in_if.bypass;
      end
      for (int i = 1; i < int'(IN_STAGES); i++) begin
        in_vld_q[i] <= in_vld_q[i-1];
        if (in_vld_q[i-1]) begin
          in_dat_q[i] <= in_dat_q[i-1];
          in_byp_q[i] <= in_byp_q[i-1];
        end
      end
      out_vld_q[0] <= in_vld_q[IN_STAGES-1];
      if (in_vld_q[IN_STAGES-1]) out_dat_q[0] <= lane_dat;
      for (int i = 1; i < int'(OUT_STAGES); i++) begin
        out_vld_q[i] <= out_vld_q[i-1];
        if (out_vld_q[i-1]) out_dat_q[i] <= out_dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (out_xfer && xfer_count != 16'hFFFF) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

`ifdef SBOX_TT_SIGNATURE_EN
  logic [W-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else if (out_xfer) begin
      sig_q <= {sig_q[W-2:0], sig_q[W-1]} ^ out_if.data;
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = '0;
`endif

endmodule
